bank_write_scheduler: RTL and testbench

//  Downstream consumer of the row/column -> bank/entry skew mapping. Takes a batch of

---
 rtl/bank_write_scheduler.sv | 153 +++++++++++++++
 tb/tb_bank_write_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bank_write_scheduler.sv
// Maps batches of (row, column, data) lanes onto skewed accumulator banks, one write per bank per cycle.
// Optional conflict/write counters are enabled by defining BWS_CONFLICT_STATS_EN.
module bank_write_scheduler #(
  parameter int unsigned    BANK_COUNT = 32,
  parameter int unsigned    TILE_SIZE  = 256,
  parameter int unsigned    LANES      = 4,
  parameter int unsigned    DATA_WIDTH = 16,
  localparam int unsigned   RW         = $clog2(TILE_SIZE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0]                 lane_valid,
  input  logic [LANES*RW-1:0]              in_row,
  input  logic [LANES*RW-1:0]              in_column,
  input  logic [LANES*DATA_WIDTH-1:0]      in_data,
  output logic [BANK_COUNT-1:0]            wr_en,
  output logic [BANK_COUNT*RW-1:0]         wr_entry,
  output logic [BANK_COUNT*DATA_WIDTH-1:0] wr_data,
`ifdef BWS_CONFLICT_STATS_EN
  input  logic                             stats_clr,
  output logic [31:0]                      conflict_cycles,
  output logic [31:0]                      lanes_written,
`endif
  output logic                             busy
);

  localparam int unsigned BW = $clog2(BANK_COUNT);
  localparam int unsigned SW = RW + 2;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                              state_q, state_d;
  logic [LANES-1:0]                    pending_q, pending_d;
  logic [LANES-1:0][RW-1:0]            row_q, row_d;
  logic [LANES-1:0][RW-1:0]            col_q, col_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]    data_q, data_d;

  logic [SW-1:0]    shift_c [LANES];
  logic [BW-1:0]    bank_c  [LANES];
  logic [LANES-1:0] grant_c;
  logic             last_c;
  logic             accept_c;

  // Skewed bank per lane; the low BW bits of the sum give the mod for a power-of-two bank count.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      shift_c[i] = SW'(row_q[i]) * SW'(3);
      bank_c[i]  = BW'(col_q[i]) + BW'(shift_c[i]);
    end
  end

  // Each bank grants its lowest-index pending lane.
  always_comb begin
    grant_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      grant_c[i] = pending_q[i] && (state_q == DRAIN);
      for (int unsigned j = 0; j < i; j++) begin
        if (pending_q[j] && (bank_c[j] == bank_c[i])) grant_c[i] = 1'b0;
      end
    end
  end

  always_comb begin
    wr_en    = '0;
    wr_entry = '0;
    wr_data  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (grant_c[i]) begin
        wr_en[bank_c[i]]                                      = 1'b1;
        wr_entry[int'(bank_c[i]) * RW +: RW]                  = row_q[i];
        wr_data[int'(bank_c[i]) * DATA_WIDTH +: DATA_WIDTH]   = data_q[i];
      end
    end
  end

  assign last_c   = ((pending_q & ~grant_c) == '0);
  assign in_ready = (state_q == IDLE) || last_c;
  assign busy     = (state_q == DRAIN);
  assign accept_c = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    if (accept_c) begin
      row_d     = in_row;
      col_d     = in_column;
      data_d    = in_data;
      pending_d = lane_valid;
      state_d   = (lane_valid != '0) ? DRAIN : IDLE;
    end else if (state_q == DRAIN) begin
      pending_d = pending_q & ~grant_c;
      if (last_c) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      row_q     <= row_d;
      col_q     <= col_d;
      data_q    <= data_d;
    end
  end

`ifdef BWS_CONFLICT_STATS_EN
  logic [31:0] conflict_q, conflict_d;
  logic [31:0] written_q, written_d;
  logic [32:0] written_sum_c;

  // Saturating counters; clear wins over increment.
  always_comb begin
    written_sum_c = 33'(written_q);
    for (int unsigned i = 0; i < LANES; i++) begin
      written_sum_c = written_sum_c + 33'(grant_c[i]);
    end
    written_d  = written_sum_c[32] ? 32'hFFFF_FFFF : written_sum_c[31:0];
    conflict_d = conflict_q;
    if ((state_q == DRAIN) && !last_c && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
    if (stats_clr) begin
      written_d  = '0;
      conflict_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      written_q  <= '0;
    end else begin
      conflict_q <= conflict_d;
      written_q  <= written_d;
    end
  end

  assign conflict_cycles = conflict_q;
  assign lanes_written   = written_q;
`endif

endmodule

// File: tb/tb_bank_write_scheduler.sv
// Directed bench for bank_write_scheduler with hand-computed bank/entry/data expectations.
module tb_bank_write_scheduler;

  localparam int unsigned BANK_COUNT = 32;
  localparam int unsigned TILE_SIZE  = 256;
  localparam int unsigned LANES      = 4;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned RW         = 8;

  logic                             clk;
  logic                             rst_n;
  logic                             in_valid;
  logic                             in_ready;
  logic [LANES-1:0]                 lane_valid;
  logic [LANES*RW-1:0]              in_row;
  logic [LANES*RW-1:0]              in_column;
  logic [LANES*DATA_WIDTH-1:0]      in_data;
  logic [BANK_COUNT-1:0]            wr_en;
  logic [BANK_COUNT*RW-1:0]         wr_entry;
  logic [BANK_COUNT*DATA_WIDTH-1:0] wr_data;
  logic                             busy;
`ifdef BWS_CONFLICT_STATS_EN
  logic                             stats_clr;
  logic [31:0]                      conflict_cycles;
  logic [31:0]                      lanes_written;
`endif

  logic [BANK_COUNT-1:0]            exp_en;
  logic [BANK_COUNT*RW-1:0]         exp_entry;
  logic [BANK_COUNT*DATA_WIDTH-1:0] exp_data;

  int n_checks = 0;
  int n_pass   = 0;

  bank_write_scheduler #(
    .BANK_COUNT(BANK_COUNT),
    .TILE_SIZE (TILE_SIZE),
    .LANES     (LANES),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane_valid(lane_valid),
    .in_row    (in_row),
    .in_column (in_column),
    .in_data   (in_data),
    .wr_en     (wr_en),
    .wr_entry  (wr_entry),
    .wr_data   (wr_data),
`ifdef BWS_CONFLICT_STATS_EN
    .stats_clr      (stats_clr),
    .conflict_cycles(conflict_cycles),
    .lanes_written  (lanes_written),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_exp();
    exp_en    = '0;
    exp_entry = '0;
    exp_data  = '0;
  endtask

  task automatic add_exp(input int bank, input logic [RW-1:0] entry, input logic [DATA_WIDTH-1:0] data);
    exp_en[bank]                             = 1'b1;
    exp_entry[bank*RW +: RW]                 = entry;
    exp_data[bank*DATA_WIDTH +: DATA_WIDTH]  = data;
  endtask

  task automatic set_lane(input int i, input logic [RW-1:0] r, input logic [RW-1:0] c,
                          input logic [DATA_WIDTH-1:0] d);
    in_row[i*RW +: RW]                 = r;
    in_column[i*RW +: RW]              = c;
    in_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic chk_out(input string tag, input logic exp_ready, input logic exp_busy);
    chk({tag, ".wr_en"},    512'(wr_en),    512'(exp_en));
    chk({tag, ".wr_entry"}, 512'(wr_entry), 512'(exp_entry));
    chk({tag, ".wr_data"},  512'(wr_data),  512'(exp_data));
    chk({tag, ".in_ready"}, 512'(in_ready), 512'(exp_ready));
    chk({tag, ".busy"},     512'(busy),     512'(exp_busy));
  endtask

  // Four lanes that all land on bank 5: (0,5) (1,2) (2,31) (3,28).
  task automatic load_bank5_batch();
    set_lane(0, 8'd0, 8'd5,  16'h5000);
    set_lane(1, 8'd1, 8'd2,  16'h5111);
    set_lane(2, 8'd2, 8'd31, 16'h5222);
    set_lane(3, 8'd3, 8'd28, 16'h5333);
    lane_valid = 4'hF;
    in_valid   = 1'b1;
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] b5 [4];
    b5[0] = 16'h5000; b5[1] = 16'h5111; b5[2] = 16'h5222; b5[3] = 16'h5333;
    rst_n = 1'b0; in_valid = 1'b0; lane_valid = '0;
    in_row = '0; in_column = '0; in_data = '0;
`ifdef BWS_CONFLICT_STATS_EN
    stats_clr = 1'b0;
`endif
    clr_exp();

    // 1: reset
    tick();
    chk("rst.wr_en", 512'(wr_en), 512'(0));
    chk("rst.busy",  512'(busy),  512'(0));
    rst_n = 1'b1;
    tick();
    chk_out("idle", 1'b1, 1'b0);

    // 2: conflict-free batch, single cycle
    set_lane(0, 8'd0, 8'd0, 16'hAAAA);
    set_lane(1, 8'd0, 8'd1, 16'hBBBB);
    set_lane(2, 8'd0, 8'd2, 16'hCCCC);
    set_lane(3, 8'd0, 8'd3, 16'hDDDD);
    lane_valid = 4'hF; in_valid = 1'b1;
    tick();
    clr_exp();
    add_exp(0, 8'd0, 16'hAAAA); add_exp(1, 8'd0, 16'hBBBB);
    add_exp(2, 8'd0, 16'hCCCC); add_exp(3, 8'd0, 16'hDDDD);
    chk_out("t2", 1'b1, 1'b1);

    // 4: back-to-back wrap batch: (10,31)->bank29, (255,255)->bank28
    in_row = '0; in_column = '0; in_data = '0;
    set_lane(0, 8'd10,  8'd31,  16'h1234);
    set_lane(1, 8'd255, 8'd255, 16'hBEEF);
    lane_valid = 4'h3;
    tick();
    clr_exp();
    add_exp(29, 8'd10, 16'h1234); add_exp(28, 8'd255, 16'hBEEF);
    chk_out("t4", 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
    clr_exp();
    chk_out("t4.idle", 1'b1, 1'b0);

    // 3: two lanes on bank 3 serialise over two cycles
`ifdef BWS_CONFLICT_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`endif
    in_row = '0; in_column = '0; in_data = '0;
    set_lane(0, 8'd0, 8'd3, 16'h0C30);
    set_lane(1, 8'd1, 8'd0, 16'h0C31);
    lane_valid = 4'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_exp(); add_exp(3, 8'd0, 16'h0C30);
    chk_out("t3.c1", 1'b0, 1'b1);
    tick();
    clr_exp(); add_exp(3, 8'd1, 16'h0C31);
    chk_out("t3.c2", 1'b1, 1'b1);
    tick();
    clr_exp();
    chk_out("t3.idle", 1'b1, 1'b0);
`ifdef BWS_CONFLICT_STATS_EN
    chk("t3.conflict_cycles", 512'(conflict_cycles), 512'(1));
    chk("t3.lanes_written",   512'(lanes_written),   512'(2));
`endif

    // 5: empty mask then a four-way conflict on bank 5
    lane_valid = 4'h0; in_valid = 1'b1;
    tick();
    clr_exp();
    chk_out("t5.empty", 1'b1, 1'b0);
    load_bank5_batch();
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clr_exp(); add_exp(5, 8'(k), b5[k]);
      chk_out($sformatf("t5.c%0d", k), (k == 3), 1'b1);
      tick();
    end
    clr_exp();
    chk_out("t5.idle", 1'b1, 1'b0);

    // 6: async reset in the second drain cycle discards pending lanes
    load_bank5_batch();
    tick();
    in_valid = 1'b0;
    clr_exp(); add_exp(5, 8'd0, b5[0]);
    chk_out("t6.c1", 1'b0, 1'b1);
    tick();
    clr_exp(); add_exp(5, 8'd1, b5[1]);
    chk_out("t6.c2", 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.wr_en", 512'(wr_en), 512'(0));
    chk("t6.rst.busy",  512'(busy),  512'(0));
    tick();
    rst_n = 1'b1;
    clr_exp();
    chk_out("t6.rel", 1'b1, 1'b0);
    tick();
    chk_out("t6.rel2", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
